ring_counter: RTL and testbench
===============================

RING_COUNTER -- requirements
Module: ring_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter WIDTH, default 100: ring width in bits.
REQ-003 clock0  input  1  Sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 lr  input  1  Shift direction: 0 = rotate right, 1 = rotate left.
REQ-006 loopback_en  input  1  Enables the loopback integrity check.
REQ-007 counter_in  input  WIDTH  Externally looped-back copy of out.
REQ-008 loopback_error  output  1  Registered flag for a loopback mismatch.
REQ-009 out  output  WIDTH  Registered ring-counter state.

Function
REQ-010 out SHALL rotate by exactly one bit on every rising clock0 edge while reset is low; no count-enable exists.
REQ-011 lr=0 SHALL give out <= {out[0], out[WIDTH-1:1]}, so the set bit moves toward the LSB and bit 0 wraps to bit WIDTH-1.
REQ-012 lr=1 SHALL give out <= {out[WIDTH-2:0], out[WIDTH-1]}, so the set bit moves toward the MSB and bit WIDTH-1 wraps to bit 0.
REQ-013 lr SHALL be sampled at each edge; a direction change SHALL take effect on the first edge after it, with no bit lost or duplicated.
REQ-014 From reset, out SHALL remain one-hot indefinitely and SHALL return to its reset value after exactly WIDTH edges in either direction.
REQ-015 loopback_error SHALL be registered as: loopback_error <= loopback_en AND (counter_in != out), using the pre-edge values of counter_in and out.
REQ-016 With loopback_en=0, loopback_error SHALL be 0 on the next edge.
REQ-017 With counter_in tied to out, loopback_error SHALL stay 0 in both directions for any number of cycles.
REQ-018 loopback_error SHALL be level-sensitive, not sticky: it SHALL fall on the first edge where the mismatch is gone.
REQ-019 out SHALL be combinationally independent of counter_in and loopback_en.
REQ-020 X or Z on loopback_en SHALL NOT be required to produce a defined loopback_error; out SHALL be unaffected by them.

Reset
REQ-021 Asserting reset SHALL immediately (asynchronously) force out = {WIDTH-1 zeros, 1}, i.e. bit 0 set (decimal 1).
REQ-022 Asserting reset SHALL immediately force loopback_error = 0.
REQ-023 While reset is high, the state SHALL hold these values regardless of clock0, lr or loopback_en.
REQ-024 Reset asserted mid-rotation SHALL discard the current position.
REQ-025 On the first rising edge after reset deasserts, out SHALL become 2^(WIDTH-1) if lr=0, or 2 if lr=1.

Structure
REQ-026 Package ring_counter_pkg SHALL hold the default WIDTH (100), the reset-pattern constant and direction constants (DIR_RIGHT=0, DIR_LEFT=1).
REQ-027 The rotate register SHALL live in ring_counter.
REQ-028 The mismatch comparator and its flag flop SHALL be one sub-module, ring_counter_loopback_chk, parameterized by WIDTH.
REQ-029 The post-route netlist (ring_counter_post_route) SHALL keep port names, port order and widths identical and SHALL be cycle-equivalent to the RTL.

Verification
REQ-030 Reset: pulse reset for one cycle with lr=0 -> while reset is high, out=1 and loopback_error=0; one edge after release, out=2^99.
REQ-031 Right rotate: lr=0, loopback_en=1, counter_in=out, 102 edges -> the set bit moves down one position per edge and wraps from bit 0 to bit 99; loopback_error=0 throughout.
REQ-032 Left rotate: lr=1, same setup, 102 edges -> the set bit moves up one position per edge and wraps from bit 99 to bit 0; out equals its starting value after every 100 edges.
REQ-033 Mismatch: loopback_en=1 and counter_in=out XOR 1 for one cycle -> loopback_error=1 for exactly one cycle; repeat with loopback_en=0 -> loopback_error stays 0.
REQ-034 Mid-run reset: assert reset asynchronously between edges after 37 rotations -> out=1 immediately, without waiting for a clock edge.
REQ-035 Equivalence: drive identical stimulus to the RTL and the netlist -> out and loopback_error match with !== on every cycle; report the mismatch count, which must be 0.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg: shared width default, reset pattern and rotate direction constants
package ring_counter_pkg;
   localparam int WIDTH_DEF = 100;
   localparam int RESET_VAL = 1;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT = 1'b1;
endpackage

// File: rtl/ring_counter_loopback_chk.sv
// ring_counter_loopback_chk: registered level-sensitive mismatch flag between ring state and its looped-back copy
module ring_counter_loopback_chk
   import ring_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             loopback_en,
   input  logic [WIDTH-1:0] counter_in,
   input  logic [WIDTH-1:0] state,
   output logic             loopback_error
);
   always_ff @(posedge clock0 or posedge reset)
      if (reset) loopback_error <= 1'b0;
      else loopback_error <= loopback_en && (counter_in != state);
endmodule

// File: rtl/ring_counter.sv
// ring_counter: one-hot ring rotating one bit per edge with a loopback integrity check
module ring_counter
   import ring_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock0,
   input  logic             reset,
   input  logic             lr,
   input  logic             loopback_en,
   input  logic [WIDTH-1:0] counter_in,
   output logic             loopback_error,
   output logic [WIDTH-1:0] out
);
   always_ff @(posedge clock0 or posedge reset)
      if (reset) out <= WIDTH'(RESET_VAL);
      else out <= (lr == DIR_LEFT) ? {out[WIDTH-2:0], out[WIDTH-1]} : {out[0], out[WIDTH-1:1]};
   ring_counter_loopback_chk #(.WIDTH(WIDTH)) u_chk (
      .clock0(clock0),
      .reset(reset),
      .loopback_en(loopback_en),
      .counter_in(counter_in),
      .state(out),
      .loopback_error(loopback_error)
   );
endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter: randomized scoreboard bench against a set-bit-position model of the ring
module tb_ring_counter;
   localparam int W = 100;
   typedef struct {
      logic [W-1:0] out;
      logic         err;
   } exp_t;
   logic         clock0 = 1'b0;
   logic         reset = 1'b0;
   logic         lr = 1'b0;
   logic         loopback_en = 1'b0;
   logic [W-1:0] counter_in = '0;
   logic         loopback_error;
   logic [W-1:0] out;
   exp_t         sb[$];
   int           pos = 0;
   int           checks = 0;
   int           errors = 0;
   ring_counter #(.WIDTH(W)) dut (
      .clock0(clock0),
      .reset(reset),
      .lr(lr),
      .loopback_en(loopback_en),
      .counter_in(counter_in),
      .loopback_error(loopback_error),
      .out(out)
   );
   always #5 clock0 = ~clock0;
   function automatic logic [W-1:0] onehot(input int p);
      logic [W-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction
   task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
      end
   endtask
   task automatic step(input logic d, input logic e, input logic [W-1:0] mask);
      exp_t x;
      lr = d;
      loopback_en = e;
      counter_in = onehot(pos) ^ mask;
      x.err = e && (mask != '0);
      pos = d ? (pos + 1) % W : (pos + W - 1) % W;
      x.out = onehot(pos);
      sb.push_back(x);
      @(negedge clock0);
   endtask
   function automatic logic [W-1:0] rand_mask();
      logic [W-1:0] m;
      m = '0;
      if ($urandom_range(0, 3) == 0) m[$urandom_range(0, W - 1)] = 1'b1;
      return m;
   endfunction
   initial forever begin
      exp_t x;
      @(posedge clock0);
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("out", out, x.out);
         chk("loopback_error", W'(loopback_error), W'(x.err));
      end
   end
   initial begin
      logic [W-1:0] m1;
      m1 = '0;
      m1[0] = 1'b1;
      #1 reset = 1'b1;
      repeat (3) begin
         @(negedge clock0);
         lr = $urandom_range(0, 1);
         loopback_en = 1'b1;
         counter_in = ~out;
         chk("reset_out", out, W'(1));
         chk("reset_err", W'(loopback_error), '0);
      end
      reset = 1'b0;
      pos = 0;
      step(1'b0, 1'b1, '0);
      for (int i = 0; i < 102; i++) step(1'b0, 1'b1, '0);
      for (int i = 0; i < 102; i++) step(1'b1, 1'b1, '0);
      step(1'b1, 1'b1, m1);
      step(1'b1, 1'b1, '0);
      step(1'b0, 1'b1, m1);
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b0, m1);
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 300; i++) step($urandom_range(0, 1), $urandom_range(0, 1), rand_mask());
      for (int i = 0; i < 37; i++) step($urandom_range(0, 1), 1'b1, m1);
      @(posedge clock0);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_out", out, W'(1));
      chk("async_reset_err", W'(loopback_error), '0);
      repeat (2) begin
         @(negedge clock0);
         lr = $urandom_range(0, 1);
         loopback_en = 1'b1;
         counter_in = '0;
         chk("hold_reset_out", out, W'(1));
         chk("hold_reset_err", W'(loopback_error), '0);
      end
      reset = 1'b0;
      pos = 0;
      step(1'b1, 1'b1, '0);
      for (int i = 0; i < 200; i++) step($urandom_range(0, 1), $urandom_range(0, 1), rand_mask());
      @(posedge clock0);
      #2;
      chk("scoreboard_drained", W'(sb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
